fetch_prefetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues requests to a variable-latency instruction memory with at most one request outstanding. Returned instructions and their PC+4 are buffered in a small queue, and the queue presents one instruction per cycle to IF/ID. It honours pipeline stalls and branch/jump redirects, dropping stale in-flight responses.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_prefetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcinc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue of {instr, pcinc}; head is read combinationally from the array.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;

  assign push_ok = push && !flush && (count != FULL);
  assign pop_ok  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data array needs no reset: the top gates head with the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch PC owner and single-outstanding imem requester feeding IF/ID through a prefetch queue.
// Optional FETCH_BYPASS_EN forwards a response straight to out_* when the queue is empty.
//  state | meaning
//  IDLE  | nothing outstanding
//  WAIT  | request outstanding, response will be kept
//  DRAIN | request outstanding, response will be discarded
module fetch_prefetch_queue import fetch_pkg::*; #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pcinc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   fpc, fpc_nxt, req_addr, req_addr_nxt;
  logic [CW-1:0] count, count_after;
  logic          q_empty, rsp, bypass, push, pop, flush;
  fetch_entry_t  head, push_entry;

  assign q_empty = (count == '0);
  assign rsp     = (state == WAIT) && imem_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp && q_empty && !redirect && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign push        = rsp && !redirect && !bypass;
  assign pop         = !q_empty && !stall && !redirect;
  assign flush       = redirect && (state != DRAIN);
  assign count_after = count + CW'(push) - CW'(pop);
  assign push_entry  = '{instr: imem_rdata, pcinc: fpc + PC_INC};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (push_entry),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fpc_nxt      = fpc;
    req_addr_nxt = req_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          fpc_nxt = redirect_pc;
        end else if (count < DEPTH_C) begin
          state_nxt    = WAIT;
          req_addr_nxt = fpc;
        end
      end
      WAIT: begin
        if (redirect) begin
          fpc_nxt   = redirect_pc;
          state_nxt = imem_valid ? IDLE : DRAIN;
        end else if (imem_valid) begin
          fpc_nxt = fpc + PC_INC;
          // Chain the next request only if it cannot overfill the queue.
          if (count_after < DEPTH_C) req_addr_nxt = fpc + PC_INC;
          else                       state_nxt    = IDLE;
        end
      end
      DRAIN: begin
        if (redirect)   fpc_nxt   = redirect_pc;
        if (imem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;

  always_comb begin
    out_valid = 1'b0;
    out_instr = NOP_INSTR;
    out_pcinc = '0;
    if (bypass) begin
      out_valid = 1'b1;
      out_instr = imem_rdata;
      out_pcinc = fpc + PC_INC;
    end else if (!q_empty) begin
      out_valid = 1'b1;
      out_instr = head.instr;
      out_pcinc = head.pcinc;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a latency-programmable imem model.
module tb_fetch_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        force_valid = 1'b0;
  logic        imem_req, imem_valid, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pcinc;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  always #5 clk = ~clk;

  // Memory answers once a request has been held for mem_lat cycles; word = A000_0000 + addr/4.
  assign imem_valid = (imem_req && (mem_cnt >= mem_lat - 1)) || force_valid;
  assign imem_rdata = 32'hA000_0000 + (imem_addr >> 2);

  always @(posedge clk or negedge reset) begin
    if (!reset)                      mem_cnt <= 0;
    else if (imem_req && imem_valid) mem_cnt <= 0;
    else if (imem_req)               mem_cnt <= mem_cnt + 1;
    else                             mem_cnt <= 0;
  end

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pcinc   (out_pcinc)
  );

  // Reset pulse; release happens at a negedge so the next negedge is cycle 1.
  task automatic do_reset(input logic st, input int lat);
    @(negedge clk);
    reset = 1'b0;
    redirect = 1'b0;
    stall = st;
    mem_lat = lat;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    n_checks++; if (out_pcinc !== 32'h0) begin n_fail++; $display("FAIL reset_pcinc got %h exp 0", out_pcinc); end
  endtask

  task automatic test_stream;
    do_reset(1'b0, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c - 1))) begin
          n_fail++; $display("FAIL stream_addr c%0d got req=%b addr=%h exp addr %h", c, imem_req, imem_addr, 32'(4 * (c - 1)));
        end
      end
      if (c == 1) begin
        n_checks++;
        if (out_valid !== 1'(BYP)) begin n_fail++; $display("FAIL stream_first_valid got %b exp %0d", out_valid, BYP); end
`ifdef FETCH_BYPASS_EN
        n_checks++;
        if (out_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL bypass_instr got %h exp A0000000", out_instr); end
`endif
      end
      if (c >= 2 - BYP && c <= 5 - BYP) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pcinc !== 32'(4 * (c - 1 + BYP))) begin
          n_fail++; $display("FAIL stream_pcinc c%0d got v=%b pcinc=%h exp %h", c, out_valid, out_pcinc, 32'(4 * (c - 1 + BYP)));
        end
      end
    end
  endtask

  task automatic test_stall;
    do_reset(1'b1, 1);
    repeat (10) @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b exp 0", imem_req); end
    n_checks++; if (dut.count !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d exp 4", dut.count); end
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pcinc !== 32'(4 * (k + 1))) begin
        n_fail++; $display("FAIL stall_drain k%0d got v=%b pcinc=%h exp %h", k, out_valid, out_pcinc, 32'(4 * (k + 1)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_drain;
    logic found;
    do_reset(1'b0, 3);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h8) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL drain_find_req8 got %b exp 1", found); end
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL drain_hold got req=%b addr=%h exp 1/8", imem_req, imem_addr); end
    n_checks++; if (dut.count !== 3'd0) begin n_fail++; $display("FAIL drain_flush got %0d exp 0", dut.count); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr !== 32'h8) begin found = 1'b1; break; end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_out got v=%b pcinc=%h exp v=0", out_valid, out_pcinc); end
      @(negedge clk);
    end
    n_checks++; if (found !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL drain_next_addr got %h exp 100", imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1'b1 || out_pcinc !== 32'h104) begin n_fail++; $display("FAIL drain_first_pcinc got %h exp 104", out_pcinc); end
    n_checks++; if (out_instr !== 32'hA000_0040) begin n_fail++; $display("FAIL drain_first_instr got %h exp A0000040", out_instr); end
  endtask

  task automatic test_redirect_same;
    logic found;
    do_reset(1'b0, 1);
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL same_not_enq got v=%b pcinc=%h exp v=0", out_valid, out_pcinc); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL same_idle_req got %b exp 0", imem_req); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL same_next_addr got req=%b addr=%h exp 1/40", imem_req, imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1'b1 || out_pcinc !== 32'h44) begin n_fail++; $display("FAIL same_first_pcinc got %h exp 44", out_pcinc); end
  endtask

  task automatic test_reset_mid;
    logic found;
    do_reset(1'b1, 1);
    repeat (4) @(negedge clk);
    n_checks++; if (dut.count !== 3'd3) begin n_fail++; $display("FAIL mid_count got %0d exp 3", dut.count); end
    n_checks++; if (out_valid !== 1'b1 || out_pcinc !== 32'h4) begin n_fail++; $display("FAIL mid_head got v=%b pcinc=%h exp 1/4", out_valid, out_pcinc); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_async_req got req=%b addr=%h exp 0/0", imem_req, imem_addr); end
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pcinc !== 32'h0) begin
      n_fail++; $display("FAIL mid_async_out got v=%b instr=%h pcinc=%h exp 0/0/0", out_valid, out_instr, out_pcinc);
    end
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    n_checks++; if (dut.count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ignore_rsp got count=%0d v=%b exp 0/0", dut.count, out_valid); end
    stall = 1'b0;
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart_addr got %h exp 0", imem_addr); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1'b1 || out_pcinc !== 32'h4) begin n_fail++; $display("FAIL mid_restart_pcinc got %h exp 4", out_pcinc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_same();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
